// File: rtl/light_phase_monitor.sv
// ---------------------------------------------------------------------------
// LightPhaseMonitor : light_phase_monitor
//
// Purpose
//   Watches the four lane light codes of an intersection controller and
//   checks the green rotation E -> W -> S -> N -> E.  Each phase must hold
//   green for exactly DWELL_TICKS samples.  The first violation latches a
//   sticky fault with its cause.  Samples are evaluated only on clk edges
//   where tick is high.
//
// Ports
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  synchronous active-high reset
//   tick        in   1  sample strobe (one clk wide)
//   fault_clr   in   1  return to SYNC from any state (LPM_FAULT_CLEAR_EN only)
//   lt_e/w/s/n  in   2  lane light codes: 01 go, 10 stop, 00/11 illegal
//   phase       out  2  current green lane (0=E 1=W 2=S 3=N)
//   phase_vld   out  1  high while tracking a locked rotation
//   dwell       out  4  valid samples counted in the current phase
//   phase_chg   out  1  one-clk pulse after each accepted phase change
//   fault       out  1  sticky fault flag
//   fault_code  out  3  first fault cause:
//                       1 illegal, 2 green count, 3 order, 4 short, 5 long
//
// Configuration
//   LPM_FAULT_CLEAR_EN : when defined, adds the fault_clr input.
// ---------------------------------------------------------------------------
module light_phase_monitor #(
    parameter int unsigned DWELL_TICKS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
`ifdef LPM_FAULT_CLEAR_EN
    input  logic       fault_clr,
`endif
    input  logic [1:0] lt_e,
    input  logic [1:0] lt_w,
    input  logic [1:0] lt_s,
    input  logic [1:0] lt_n,
    output logic [1:0] phase,
    output logic       phase_vld,
    output logic [3:0] dwell,
    output logic       phase_chg,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0] CODE_GO   = 2'b01;
    localparam logic [1:0] CODE_STOP = 2'b10;
    localparam logic [3:0] DWELL_MAX = 4'(DWELL_TICKS);

    localparam logic [2:0] FC_ILLEGAL = 3'd1;
    localparam logic [2:0] FC_COUNT   = 3'd2;
    localparam logic [2:0] FC_ORDER   = 3'd3;
    localparam logic [2:0] FC_SHORT   = 3'd4;
    localparam logic [2:0] FC_LONG    = 3'd5;

    state_t     r_state,     w_state;
    logic [1:0] r_phase,     w_phase;
    logic       r_phaseVld,  w_phaseVld;
    logic [3:0] r_dwell,     w_dwell;
    logic       r_phaseChg,  w_phaseChg;
    logic       r_fault,     w_fault;
    logic [2:0] r_faultCode, w_faultCode;
    logic [1:0] r_prevLane,  w_prevLane;
    logic       r_prevVld,   w_prevVld;

    logic       w_clear;
    logic       w_legal;
    logic [3:0] w_go;
    logic [2:0] w_goCount;
    logic [1:0] w_lane;
    logic [1:0] w_laneNext;
    logic [3:0] w_dwellInc;
    logic       w_enterFault;
    logic [2:0] w_newCode;

`ifdef LPM_FAULT_CLEAR_EN
    assign w_clear = fault_clr;
`else
    assign w_clear = 1'b0;
`endif

    // Decode the current sample: legality of every lane, which lanes show
    // go, how many, and the encoded green lane (only meaningful when
    // exactly one lane is green).
    always_comb begin
        w_legal = ((lt_e == CODE_GO) || (lt_e == CODE_STOP)) &&
                  ((lt_w == CODE_GO) || (lt_w == CODE_STOP)) &&
                  ((lt_s == CODE_GO) || (lt_s == CODE_STOP)) &&
                  ((lt_n == CODE_GO) || (lt_n == CODE_STOP));
        w_go      = {lt_n == CODE_GO, lt_s == CODE_GO,
                     lt_w == CODE_GO, lt_e == CODE_GO};
        w_goCount = 3'(w_go[0]) + 3'(w_go[1]) + 3'(w_go[2]) + 3'(w_go[3]);
        w_lane    = 2'd0;
        if (w_go[1]) w_lane = 2'd1;
        if (w_go[2]) w_lane = 2'd2;
        if (w_go[3]) w_lane = 2'd3;
        w_laneNext = r_phase + 2'd1;
        w_dwellInc = (r_dwell == 4'hF) ? 4'hF : r_dwell + 4'd1;
    end

    // Next-state and next-output logic.  Fault causes are tested in
    // priority order so the first matching check wins; the fault itself is
    // applied after the state case so phase and dwell stay frozen at their
    // pre-fault values.
    always_comb begin
        w_state      = r_state;
        w_phase      = r_phase;
        w_phaseVld   = r_phaseVld;
        w_dwell      = r_dwell;
        w_phaseChg   = 1'b0;
        w_fault      = r_fault;
        w_faultCode  = r_faultCode;
        w_prevLane   = r_prevLane;
        w_prevVld    = r_prevVld;
        w_enterFault = 1'b0;
        w_newCode    = 3'd0;

        if (w_clear) begin
            w_state     = SYNC;
            w_phase     = 2'd0;
            w_phaseVld  = 1'b0;
            w_dwell     = 4'd0;
            w_fault     = 1'b0;
            w_faultCode = 3'd0;
            w_prevLane  = 2'd0;
            w_prevVld   = 1'b0;
        end else if (tick) begin
            case (r_state)
                SYNC: begin
                    if (!w_legal) begin
                        w_enterFault = 1'b1;
                        w_newCode    = FC_ILLEGAL;
                    end else if (w_goCount != 3'd1) begin
                        w_enterFault = 1'b1;
                        w_newCode    = FC_COUNT;
                    end else begin
                        // Lock onto the first observed lane change; the
                        // partial phase before it is neither timed nor
                        // order checked.
                        if (r_prevVld && (w_lane != r_prevLane)) begin
                            w_state    = TRACK;
                            w_phase    = w_lane;
                            w_dwell    = 4'd1;
                            w_phaseVld = 1'b1;
                            w_phaseChg = 1'b1;
                        end
                        w_prevLane = w_lane;
                        w_prevVld  = 1'b1;
                    end
                end
                TRACK: begin
                    if (!w_legal) begin
                        w_enterFault = 1'b1;
                        w_newCode    = FC_ILLEGAL;
                    end else if (w_goCount != 3'd1) begin
                        w_enterFault = 1'b1;
                        w_newCode    = FC_COUNT;
                    end else if (w_lane == r_phase) begin
                        if (r_dwell >= DWELL_MAX) begin
                            w_enterFault = 1'b1;
                            w_newCode    = FC_LONG;
                        end else begin
                            w_dwell = w_dwellInc;
                        end
                    end else if (w_lane != w_laneNext) begin
                        w_enterFault = 1'b1;
                        w_newCode    = FC_ORDER;
                    end else if (r_dwell != DWELL_MAX) begin
                        w_enterFault = 1'b1;
                        w_newCode    = FC_SHORT;
                    end else begin
                        w_phase    = w_lane;
                        w_dwell    = 4'd1;
                        w_phaseChg = 1'b1;
                    end
                    w_prevLane = w_lane;
                end
                default: begin
                end
            endcase

            if (w_enterFault) begin
                w_state     = FAULT;
                w_fault     = 1'b1;
                w_faultCode = w_newCode;
                w_phaseVld  = 1'b0;
                w_phase     = r_phase;
                w_dwell     = r_dwell;
                w_phaseChg  = 1'b0;
            end
        end
    end

    // State and output registers; reset overrides tick, fault and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SYNC;
            r_phase     <= 2'd0;
            r_phaseVld  <= 1'b0;
            r_dwell     <= 4'd0;
            r_phaseChg  <= 1'b0;
            r_fault     <= 1'b0;
            r_faultCode <= 3'd0;
            r_prevLane  <= 2'd0;
            r_prevVld   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_phase     <= w_phase;
            r_phaseVld  <= w_phaseVld;
            r_dwell     <= w_dwell;
            r_phaseChg  <= w_phaseChg;
            r_fault     <= w_fault;
            r_faultCode <= w_faultCode;
            r_prevLane  <= w_prevLane;
            r_prevVld   <= w_prevVld;
        end
    end

    assign phase      = r_phase;
    assign phase_vld  = r_phaseVld;
    assign dwell      = r_dwell;
    assign phase_chg  = r_phaseChg;
    assign fault      = r_fault;
    assign fault_code = r_faultCode;

endmodule
